// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding memory read, a one-entry fetch buffer
// toward decode, and redirect-driven flushing of in-flight requests.
`timescale 1ns/1ps
module instr_fetch #(
  parameter int unsigned width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] pc_in,
  output logic             pc_load,
  output logic [width-1:0] pc_next,
  output logic             mem_read,
  output logic [width-1:0] mem_address,
  input  logic             mem_resp,
  input  logic [width-1:0] mem_rdata,
  input  logic             redirect,
  input  logic [width-1:0] redirect_target,
  input  logic             id_ready,
  output logic             if_valid,
  output logic [width-1:0] if_instr,
  output logic [width-1:0] if_pc
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DRAIN
  } state_e;

  localparam logic [width-1:0] INSTR_BYTES = width'(4);

  state_e           state_q;
  logic             mem_read_q;
  logic [width-1:0] addr_q;
  logic             valid_q;
  logic [width-1:0] instr_q;
  logic [width-1:0] pc_q;
  logic             fetch_done;
  logic [width-1:0] seq_pc_d;

  assign fetch_done = (state_q == BUSY) && mem_resp;
  assign seq_pc_d   = addr_q + INSTR_BYTES;

  // Redirect wins over the sequential update; rst_n gating keeps the PC
  // register from loading while the block is held in reset.
  always_comb begin
    pc_load = 1'b0;
    pc_next = seq_pc_d;
    if (rst_n) begin
      if (redirect) begin
        pc_load = 1'b1;
        pc_next = redirect_target;
      end else if (fetch_done) begin
        pc_load = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mem_read_q <= 1'b0;
      addr_q     <= '0;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      pc_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (redirect) begin
            valid_q <= 1'b0;
          end else if (!valid_q || id_ready) begin
            state_q    <= BUSY;
            mem_read_q <= 1'b1;
            addr_q     <= pc_in;
            valid_q    <= 1'b0;
          end
        end
        BUSY: begin
          if (mem_resp) begin
            state_q    <= IDLE;
            mem_read_q <= 1'b0;
            if (!redirect) begin
              valid_q <= 1'b1;
              instr_q <= mem_rdata;
              pc_q    <= addr_q;
            end
          end else if (redirect) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          // The stale response retires the request even if another redirect
          // lands on the same cycle; nothing else is outstanding to wait for.
          if (mem_resp) begin
            state_q    <= IDLE;
            mem_read_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          mem_read_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_read    = mem_read_q;
  assign mem_address = addr_q;
  assign if_valid    = valid_q;
  assign if_instr    = instr_q;
  assign if_pc       = pc_q;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have one parameter: width, default 32, datapath/address width in bits.
REQ-002 Clock and reset SHALL be as follows: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 pc_in  input  width  current PC from the PC register.
REQ-006 pc_load  output  1  load strobe to the PC register.
REQ-007 pc_next  output  width  value the PC register captures when pc_load=1.
REQ-008 mem_read  output  1  instruction memory read request.
REQ-009 mem_address  output  width  instruction memory address.
REQ-010 mem_resp  input  1  one-cycle memory completion pulse.
REQ-011 mem_rdata  input  width  instruction word; valid when mem_resp=1.
REQ-012 redirect  input  1  branch/jump flush from a later stage.
REQ-013 redirect_target  input  width  new PC; valid when redirect=1.
REQ-014 id_ready  input  1  decode stage accepts if_instr this cycle.
REQ-015 if_valid  output  1  fetch buffer holds an instruction.
REQ-016 if_instr  output  width  buffered instruction.
REQ-017 if_pc  output  width  address of if_instr.

Function
REQ-018 The FSM SHALL have three states: IDLE, BUSY and DRAIN.
REQ-019 mem_read SHALL be 1 exactly when state is BUSY or DRAIN.
REQ-020 mem_address SHALL be a register and SHALL be held stable from request start until mem_resp.
REQ-021 The fetch buffer SHALL be one entry (if_valid, if_instr, if_pc), all registered.
REQ-022 A transfer SHALL occur on any cycle with if_valid=1 and id_ready=1; if_valid SHALL clear next cycle unless it is reloaded.
REQ-023 IDLE, no redirect: if (!if_valid || id_ready), the FSM SHALL go to BUSY and capture mem_address<=pc_in; otherwise it SHALL stay IDLE.
REQ-024 BUSY, mem_resp=1, no redirect: next cycle the block SHALL set if_instr<=mem_rdata, if_pc<=mem_address and if_valid<=1, and go to IDLE.
REQ-025 In that same cycle the block SHALL drive pc_load=1 and pc_next=mem_address+4.
REQ-026 BUSY, mem_resp=0, no redirect: the FSM SHALL stay BUSY with pc_load=0.
REQ-027 Redirect in any state: the block SHALL drive pc_load=1 and pc_next=redirect_target combinationally in that cycle, and if_valid SHALL be 0 next cycle.
REQ-028 Redirect has priority over id_ready and over a mem_resp-driven PC update.
REQ-029 Redirect in IDLE: the FSM SHALL stay IDLE and SHALL NOT start a request in that cycle, so that pc_in reflects the target first.
REQ-030 Redirect in BUSY with mem_resp=1: mem_rdata SHALL be discarded and the FSM SHALL go to IDLE.
REQ-031 Redirect in BUSY with mem_resp=0: the FSM SHALL go to DRAIN, with mem_read and mem_address held.
REQ-032 DRAIN: the block SHALL wait for mem_resp, discard mem_rdata, leave the buffer untouched and go to IDLE.
REQ-033 A further redirect in DRAIN SHALL again drive pc_load/pc_next and SHALL leave the state at DRAIN.
REQ-034 Outside REQ-025 and REQ-027, pc_load SHALL be 0.
REQ-035 Any pc_next value with pc_load=0 SHALL be don't-care.
REQ-036 Address arithmetic SHALL be modulo 2^width; 0xFFFFFFFC+4 SHALL yield 0x00000000.
REQ-037 mem_resp in IDLE SHALL be ignored.
REQ-038 The buffer SHALL be empty throughout BUSY, so no instruction is ever overwritten or lost.

Reset
REQ-039 While rst_n=0, regardless of clk, the block SHALL force state=IDLE, if_valid=0, if_instr=0, if_pc=0 and mem_address=0.
REQ-040 During reset, mem_read and pc_load SHALL read 0.
REQ-041 Reset asserted mid-request SHALL abandon the request immediately, with mem_read falling asynchronously.
REQ-042 The first cycle after reset release SHALL enter BUSY with mem_address=pc_in (PC register reset value 0x00000060).

Verification
REQ-043 Reset release, pc_in=0x60, mem_resp one cycle after mem_read, id_ready=1 -> mem_address=0x60; pc_load=1 and pc_next=0x64 on the resp cycle; if_valid=1 with if_pc=0x60 and if_instr=mem_rdata next cycle.
REQ-044 id_ready=0 for 5 cycles after the first fetch -> mem_read stays 0 and if_instr/if_pc hold; when id_ready rises, the next request to 0x64 starts that cycle.
REQ-045 Redirect to 0x200 while BUSY and mem_resp delayed 3 cycles -> pc_load=1 with pc_next=0x200 that cycle; FSM in DRAIN with mem_address unchanged; stale resp discarded with if_valid=0; next request goes to 0x200.
REQ-046 Redirect coincident with mem_resp -> pc_next=redirect_target (not +4) and if_valid stays 0.
REQ-047 pc_in=0xFFFFFFFC fetch -> pc_next=0x00000000.
REQ-048 rst_n dropped while BUSY -> mem_read falls without a clock edge; after release the block refetches from 0x60.
